// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with a frame-synchronous double-buffered display register.
// Optional build macro SEG7_LEADING_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seg7_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start,
  output logic                  pending
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PC_W  = $clog2(SCAN_DIV);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [PC_W-1:0]  PC_BLANK = PC_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Active-low {g,f,e,d,c,b,a}; all sixteen codes listed, so no default path exists.
  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'b1000000;
      4'h1: code = 7'b1111001;
      4'h2: code = 7'b0100100;
      4'h3: code = 7'b0110000;
      4'h4: code = 7'b0011001;
      4'h5: code = 7'b0010010;
      4'h6: code = 7'b0000010;
      4'h7: code = 7'b1111000;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0010000;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b0000011;
      4'hC: code = 7'b1000110;
      4'hD: code = 7'b0100001;
      4'hE: code = 7'b0000110;
      4'hF: code = 7'b0001110;
    endcase
    return code;
  endfunction

  logic [PC_W-1:0]     pcnt_q, pcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d, shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, shadow_dp_q, shadow_dp_d;
  logic                pending_q, pending_d;
  logic                frame_start_q, frame_start_d;
  logic [6:0]          seg_q, seg_d;
  logic                seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                tick, wrap;
  logic [3:0]          cur_nib;

`ifdef SEG7_LEADING_BLANK_EN
  logic [DIGITS-1:0] suppress;

  always_comb begin : lead_blank
    logic run;
    suppress = '0;
    run      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run         = run & (disp_val_q[4*i +: 4] == 4'h0) & ~disp_dp_q[i];
      suppress[i] = run;
    end
  end
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tick          = (pcnt_q == PC_LAST);
    wrap          = tick && (idx_q == IDX_LAST);
    pcnt_d        = tick ? '0 : pcnt_q + 1'b1;
    idx_d         = idx_q;
    disp_val_d    = disp_val_q;
    disp_dp_d     = disp_dp_q;
    shadow_val_d  = shadow_val_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    frame_start_d = wrap;

    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    // A load on the boundary bypasses the shadow wait; otherwise the boundary drains the shadow.
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      if (wrap) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
        pending_d  = 1'b0;
      end else begin
        pending_d  = 1'b1;
      end
    end else if (wrap && pending_q) begin
      disp_val_d = shadow_val_q;
      disp_dp_d  = shadow_dp_q;
      pending_d  = 1'b0;
    end

    cur_nib = disp_val_q[{idx_q, 2'b00} +: 4];
    an_d     = '1;
    seg_d    = 7'h7F;
    seg_dp_d = 1'b1;
    if (enable && (pcnt_q >= PC_BLANK)) begin
      an_d     = ~(DIGITS'(1) << idx_q);
      seg_d    = encode(cur_nib);
      seg_dp_d = ~disp_dp_q[idx_q];
`ifdef SEG7_LEADING_BLANK_EN
      if (suppress[idx_q]) seg_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      idx_q         <= '0;
      disp_val_q    <= '0;
      disp_dp_q     <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      seg_q         <= 7'h7F;
      seg_dp_q      <= 1'b1;
      an_q          <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      pcnt_q        <= pcnt_d;
      idx_q         <= idx_d;
      disp_val_q    <= disp_val_d;
      disp_dp_q     <= disp_dp_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      an_q          <= an_d;
    end
  end

  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: cycle-count based reference model plus directed literal checks.
module tb_seg7_scan_driver;

  localparam int DG = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic [6:0]    seg;
  logic          seg_dp;
  logic [3:0]    an;
  logic          frame_start;
  logic          pending;

  int n_chk  = 0;
  int n_fail = 0;

  seg7_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .seg(seg), .seg_dp(seg_dp), .an(an), .frame_start(frame_start), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Encoding table straight from the display's code list.
  logic [6:0] enc_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: position in the scan derived purely from cycles elapsed since reset.
  int          m_cyc  = 0;
  logic [15:0] m_disp = '0, m_shv = '0;
  logic [3:0]  m_ddp  = '0, m_shd = '0;
  logic        m_pend = 1'b0;
  logic [3:0]  e_an   = '1;
  logic [6:0]  e_seg  = 7'h7F;
  logic        e_dp   = 1'b1;
  logic        e_fs   = 1'b0;

  function automatic bit lead_suppressed(input int d, input logic [15:0] v, input logic [3:0] dp);
`ifdef SEG7_LEADING_BLANK_EN
    if (d == 0) return 1'b0;
    for (int j = d; j < DG; j++)
      if (((v >> (4*j)) & 16'hF) != 0 || dp[j]) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int pc, ix;
    bit bnd;
    if (!rst_n) begin
      m_cyc = 0; m_disp = '0; m_ddp = '0; m_shv = '0; m_shd = '0; m_pend = 1'b0;
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    end else begin
      pc  = m_cyc % SD;
      ix  = (m_cyc / SD) % DG;
      bnd = (m_cyc % (DG*SD)) == (DG*SD - 1);
      if (!enable || pc < BC) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = 4'hF ^ (4'b0001 << ix);
        e_seg = lead_suppressed(ix, m_disp, m_ddp) ? 7'h7F : enc_tab[(m_disp >> (4*ix)) & 16'hF];
        e_dp  = ~m_ddp[ix];
      end
      e_fs = bnd;
      if (load && bnd) begin
        m_disp = value; m_ddp = dp_in; m_shv = value; m_shd = dp_in; m_pend = 1'b0;
      end else if (load) begin
        m_shv = value; m_shd = dp_in; m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_disp = m_shv; m_ddp = m_shd; m_pend = 1'b0;
      end
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("model_an", an, e_an);
    check("model_seg", seg, e_seg);
    check("model_seg_dp", seg_dp, e_dp);
    check("model_frame_start", frame_start, e_fs);
    check("model_pending", pending, m_pend);
  end

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 4*DG*SD && !seen; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s_frame_wait: frame_start never seen, required within %0d cycles", tag, 4*DG*SD);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    load = 1'b1; value = v; dp_in = dp;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called on the frame_start sample; walks one full frame of output slots.
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpn);
    int lit0 = 0;
    for (int k = 1; k <= DG*SD; k++) begin
      @(negedge clk);
      if (an === 4'b1110) lit0++;
      if (k == 9) check({tag, "_blank_gap"}, an, 4'b1111);
      for (int d = 0; d < DG; d++) begin
        if (k == 3 + SD*d) begin
          check($sformatf("%s_an%0d", tag, d), an, 4'hF ^ (4'b0001 << d));
          check($sformatf("%s_seg%0d", tag, d), seg, segs[7*d +: 7]);
          check($sformatf("%s_dp%0d", tag, d), seg_dp, dpn[d]);
        end
      end
    end
    check({tag, "_lit_cycles"}, lit0, SD - BC);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_an", an, 4'b1111);
    check("reset_seg", seg, 7'h7F);
    check("reset_pending", pending, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: 1234 shows 4,3,2,1 on digits 0..3.
    pulse_load(16'h1234, 4'h0);
    check("load_sets_pending", pending, 1'b1);
    wait_frame("basic");
    check("basic_pending_cleared", pending, 1'b0);
    check_frame("basic", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111);

    // Nibble sweep on digit 0.
    for (int n = 0; n < 16; n++) begin
      pulse_load(16'h0000 | 16'(n), 4'h0);
      wait_frame("sweep");
      repeat (3) @(negedge clk);
      check($sformatf("sweep_seg_%0h", n), seg, enc_tab[n]);
      if (n == 5)  check("sweep_lit_5", seg, 7'b0010010);
      if (n == 11) check("sweep_lit_b", seg, 7'b0000011);
      if (n == 13) check("sweep_lit_d", seg, 7'b0100001);
    end

    // Two loads in one frame: last wins.
    wait_frame("dbl_sync");
    pulse_load(16'hAAAA, 4'h0);
    check("dbl_pending_1", pending, 1'b1);
    repeat (3) @(negedge clk);
    pulse_load(16'h5555, 4'h0);
    check("dbl_pending_2", pending, 1'b1);
    wait_frame("dbl");
    check("dbl_pending_cleared", pending, 1'b0);
    repeat (3) @(negedge clk);
    check("dbl_an0", an, 4'b1110);
    check("dbl_seg_is_5", seg, 7'b0010010);

    // Load coincident with the wrapping tick.
    wait_frame("coin_sync");
    repeat (DG*SD - 1) @(negedge clk);
    pulse_load(16'h0007, 4'h1);
    check("coin_frame_start", frame_start, 1'b1);
    check("coin_pending_0", pending, 1'b0);
    repeat (3) @(negedge clk);
    check("coin_an0", an, 4'b1110);
    check("coin_seg_is_7", seg, 7'b1111000);
    check("coin_dp_on", seg_dp, 1'b0);

    // Enable low for 20 cycles mid-scan.
    repeat (5) @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("dis_an", an, 4'b1111);
      check("dis_seg", seg, 7'h7F);
    end
    enable = 1'b1;
    repeat (40) @(negedge clk);

    // Leading-zero behaviour.
    pulse_load(16'h0040, 4'h0);
    wait_frame("lead");
`ifdef SEG7_LEADING_BLANK_EN
    check_frame("lead", {7'h7F, 7'h7F, 7'b0011001, 7'b1000000}, 4'b1111);
`else
    check_frame("lead", {7'b1000000, 7'b1000000, 7'b0011001, 7'b1000000}, 4'b1111);
`endif
    pulse_load(16'h0040, 4'h8);
    wait_frame("lead_dp");
    check_frame("lead_dp", {7'b1000000, 7'b1000000, 7'b0011001, 7'b1000000}, 4'b0111);

    // Reset mid-operation drops a pending load.
    pulse_load(16'hBEEF, 4'h3);
    check("rst_pre_pending", pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_pending", pending, 1'b0);
    check("rst_mid_an", an, 4'b1111);
    check("rst_mid_seg", seg, 7'h7F);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 19) == 0);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
    end
    load = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
